// File: rtl/o3_router.sv
// 1-input, 3-output wormhole router: input flit FIFO, head-locked routing FSM,
// one-flit register per output port and a saturating drop counter.
module o3_router #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] input_data,
    input  logic        input_req,
    output logic        input_bussy,
    output logic [15:0] output_data1,
    output logic [15:0] output_data2,
    output logic [15:0] output_data3,
    output logic        output_req1,
    output logic        output_req2,
    output logic        output_req3,
    input  logic        output_bussy1,
    input  logic        output_bussy2,
    input  logic        output_bussy3,
    output logic [7:0]  drop_count
);

    localparam int unsigned FLIT_W = 16;
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned DROP_W = 8;
    localparam int unsigned NPORT  = 3;

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_e;

    state_e                  state_q, state_d;
    logic [FLIT_W-1:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    bussy_q;
    logic [NPORT-1:0]        lock_q, lock_d;
    logic [NPORT-1:0]        oreq_q;
    logic [FLIT_W-1:0]       odata_q [NPORT];
    logic [DROP_W-1:0]       drop_q;

    logic                    push, pop, drop, nonempty;
    logic                    f_head, f_tail;
    logic [FLIT_W-1:0]       head_flit;
    logic [NPORT-1:0]        dest_oh, free, load, obussy;

    assign push      = input_req & ~bussy_q;
    assign nonempty  = (count_q != '0);
    assign head_flit = mem_q[rd_ptr_q];
    assign f_head    = (head_flit[15:14] == 2'b00);
    assign f_tail    = (head_flit[15:13] == 3'b011);
    assign obussy    = {output_bussy3, output_bussy2, output_bussy1};
    assign free      = ~oreq_q | ~obussy;
    assign count_d   = count_q + CNT_W'(push) - CNT_W'(pop);

    always_comb begin
        dest_oh = '0;
        case (head_flit[12:11])
            2'b01:   dest_oh = 3'b001;
            2'b10:   dest_oh = 3'b010;
            2'b11:   dest_oh = 3'b100;
            default: dest_oh = '0;
        endcase
    end

    // Flit storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= input_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            bussy_q  <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            count_q <= count_d;
            bussy_q <= (count_d == CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
        end
    end

    // Routing decision on the FIFO head flit; a port may be reloaded while draining.
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        pop     = 1'b0;
        load    = '0;
        drop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (nonempty) begin
                    if (f_head && (dest_oh != '0)) begin
                        if ((dest_oh & free) != '0) begin
                            pop     = 1'b1;
                            load    = dest_oh;
                            lock_d  = dest_oh;
                            state_d = FWD;
                        end
                    end else begin
                        pop  = 1'b1;
                        drop = 1'b1;
                        if (f_head) state_d = DROP;
                    end
                end
            end
            FWD: begin
                if (nonempty && ((lock_q & free) != '0)) begin
                    pop  = 1'b1;
                    load = lock_q;
                    if (f_tail) state_d = IDLE;
                end
            end
            DROP: begin
                if (nonempty) begin
                    pop  = 1'b1;
                    drop = 1'b1;
                    if (f_tail) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            oreq_q <= '0;
            for (int i = 0; i < NPORT; i++) odata_q[i] <= '0;
        end else begin
            for (int i = 0; i < NPORT; i++) begin
                if (load[i]) begin
                    odata_q[i] <= head_flit;
                    oreq_q[i]  <= 1'b1;
                end else if (oreq_q[i] && !obussy[i]) begin
                    oreq_q[i]  <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_q <= '0;
        end else if (drop && (drop_q != {DROP_W{1'b1}})) begin
            drop_q <= drop_q + DROP_W'(1);
        end
    end

    assign input_bussy  = bussy_q;
    assign output_req1  = oreq_q[0];
    assign output_req2  = oreq_q[1];
    assign output_req3  = oreq_q[2];
    assign output_data1 = odata_q[0];
    assign output_data2 = odata_q[1];
    assign output_data3 = odata_q[2];
    assign drop_count   = drop_q;

endmodule

// File: tb/tb_o3_router.sv
// Scoreboarded bench for o3_router: a packet-level routing model fills per-port
// expected queues as flits are accepted; a monitor checks every delivered flit.
module tb_o3_router;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] input_data = '0;
    logic        input_req = 1'b0;
    logic        input_bussy;
    logic [15:0] output_data1, output_data2, output_data3;
    logic        output_req1, output_req2, output_req3;
    logic        ob1 = 1'b0, ob2 = 1'b0, ob3 = 1'b0;
    logic [7:0]  drop_count;

    o3_router #(.DEPTH(4), .ADDR_W(2)) dut (
        .clk(clk), .reset(reset),
        .input_data(input_data), .input_req(input_req), .input_bussy(input_bussy),
        .output_data1(output_data1), .output_data2(output_data2), .output_data3(output_data3),
        .output_req1(output_req1), .output_req2(output_req2), .output_req3(output_req3),
        .output_bussy1(ob1), .output_bussy2(ob2), .output_bussy3(ob3),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_fail = 0;
    int acc_n = 0;
    bit rand_bp = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: routing depends only on the order of accepted flits.
    logic [15:0] exp_q [3][$];
    int m_state = 0;   // 0 idle, 1 forwarding, 2 dropping
    int m_port  = 0;
    int exp_drops = 0;

    function automatic void note_drop();
        if (exp_drops < 255) exp_drops++;
    endfunction

    function automatic void model_flit(input logic [15:0] f);
        int t = int'(f[15:13]);
        int d = int'(f[12:11]);
        if (m_state == 0) begin
            if (t <= 1) begin
                if (d != 0) begin
                    m_port = d - 1;
                    exp_q[m_port].push_back(f);
                    m_state = 1;
                end else begin
                    note_drop();
                    m_state = 2;
                end
            end else begin
                note_drop();
            end
        end else if (m_state == 1) begin
            exp_q[m_port].push_back(f);
            if (t == 3) m_state = 0;
        end else begin
            note_drop();
            if (t == 3) m_state = 0;
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) exp_q[i].delete();
        m_state = 0;
        exp_drops = 0;
    endfunction

    function automatic int pending();
        return exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
    endfunction

    task automatic mon_port(input int p, input logic rq, input logic bz, input logic [15:0] d);
        logic [15:0] e;
        if (rq && !bz) begin
            if (exp_q[p].size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL port%0d_unexpected: got 0x%0h, expected no flit", p + 1, d);
            end else begin
                e = exp_q[p].pop_front();
                chk($sformatf("port%0d_data", p + 1), 32'(d), 32'(e));
            end
        end
    endtask

    // Monitor: a flit presented with bussy low transfers on the next rising edge.
    always @(negedge clk) begin
        if (reset) begin
            mon_port(0, output_req1, ob1, output_data1);
            mon_port(1, output_req2, ob2, output_data2);
            mon_port(2, output_req3, ob3, output_data3);
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_bp) begin
            ob1 = ($urandom_range(0, 3) == 0);
            ob2 = ($urandom_range(0, 3) == 0);
            ob3 = ($urandom_range(0, 3) == 0);
        end
    end

    bit lat_arm = 0, lat_seen = 0, stray23 = 0;
    int lat_cyc = 0;
    always @(negedge clk) begin
        if (lat_arm) begin
            if (output_req1 && !lat_seen) begin
                lat_seen = 1;
                lat_cyc  = cyc;
            end
            if (output_req2 || output_req3) stray23 = 1;
        end
    end

    task automatic send(input logic [15:0] f);
        input_data = f;
        input_req  = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (!input_bussy) begin
                @(posedge clk);
                #1;
                model_flit(f);
                acc_n++;
                input_req = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL send_timeout: flit 0x%0h not accepted, expected accept", f);
        input_req = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 600 && pending() != 0; k++) cycles(1);
        cycles(10);
        chk({name, "_pending"}, 32'(pending()), 0);
        chk({name, "_drops"}, 32'(drop_count), 32'(exp_drops));
        chk({name, "_in_bussy"}, 32'(input_bussy), 0);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_reqs"}, 32'({output_req1, output_req2, output_req3}), 0);
        chk({name, "_data"}, 32'(output_data1 | output_data2 | output_data3), 0);
        chk({name, "_in_bussy"}, 32'(input_bussy), 0);
        chk({name, "_drops"}, 32'(drop_count), 0);
    endtask

    initial begin
        int head_cyc;
        bit c4, c5, req1_seen;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        cycles(1);

        // Single packet to port 1, latency and isolation of ports 2/3
        lat_arm = 1;
        send(16'h2800);
        head_cyc = cyc;
        send(16'h4001);
        send(16'h4002);
        send(16'h6003);
        drain("pkt1");
        lat_arm = 0;
        chk("pkt1_latency", 32'(lat_cyc), 32'(head_cyc + 1));
        chk("pkt1_stray23", 32'(stray23), 0);

        // Backpressure on port 2 fills the FIFO
        ob2 = 1'b1;
        acc_n = 0;
        c4 = 0;
        c5 = 0;
        fork
            begin
                send(16'h3000);
                for (int i = 1; i <= 4; i++) send(16'h4100 | 16'(i));
                send(16'h6105);
            end
            begin
                for (int k = 0; k < 60 && !c5; k++) begin
                    @(negedge clk);
                    if (acc_n == 4 && !c4) begin
                        c4 = 1;
                        chk("bp_bussy_before_full", 32'(input_bussy), 0);
                    end
                    if (acc_n == 5) begin
                        c5 = 1;
                        chk("bp_bussy_after_full", 32'(input_bussy), 1);
                    end
                end
                if (!c5) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL bp_fill: FIFO never filled, expected 5 accepts");
                end
                cycles(3);
                chk("bp_hold_head", 32'(output_data2), 32'h3000);
                chk("bp_still_bussy", 32'(input_bussy), 1);
                ob2 = 1'b0;
            end
        join
        drain("bp");

        // Port lock: packet B to port 1 queued behind stalled packet A to port 3
        ob3 = 1'b1;
        send(16'h3800);
        send(16'h4011);
        send(16'h6012);
        send(16'h2800);
        send(16'h6021);
        req1_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (output_req1) req1_seen = 1;
        end
        chk("lock_port1_idle", 32'(req1_seen), 0);
        chk("lock_fifo_full", 32'(input_bussy), 1);
        cycles(1);
        ob3 = 1'b0;
        drain("lock");

        // Asynchronous reset in the middle of a stalled packet
        ob2 = 1'b1;
        send(16'h3000);
        send(16'h4201);
        cycles(2);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        #2;
        reset = 1'b1;
        ob2 = 1'b0;
        cycles(1);
        send(16'h2800);
        send(16'h6000);
        drain("post_rst");

        // Invalid destination packet, then a valid one; then an orphan tail
        send(16'h2000);
        send(16'h4000);
        send(16'h6000);
        send(16'h2800);
        send(16'h6001);
        drain("invalid");
        chk("invalid_drop3", 32'(drop_count), 3);
        send(16'h6000);
        drain("orphan");
        chk("orphan_drop4", 32'(drop_count), 4);

        // Drop counter saturation
        for (int i = 0; i < 300; i++) send(16'h4000 | 16'(i));
        drain("sat");
        chk("sat_255", 32'(drop_count), 255);
        send(16'h3800);
        send(16'h4abc);
        send(16'h6def);
        drain("sat_pkt");

        // Random packets under random backpressure
        rand_bp = 1;
        for (int p = 0; p < 40; p++) begin
            int kind = $urandom_range(0, 9);
            if (kind == 0) begin
                send({3'($urandom_range(2, 7)), 13'($urandom)});
            end else begin
                logic [1:0] d = (kind == 1) ? 2'b00 : 2'($urandom_range(1, 3));
                int nb = $urandom_range(0, 4);
                send({2'b00, 1'($urandom), d, 11'($urandom)});
                for (int b = 0; b < nb; b++) send({3'b010, 13'($urandom)});
                send({3'b011, 13'($urandom)});
            end
        end
        rand_bp = 0;
        @(posedge clk);
        #2;
        ob1 = 1'b0;
        ob2 = 1'b0;
        ob3 = 1'b0;
        drain("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
